// File: rtl/sobel_pkg.sv
// sobel_pkg: shared widths, window type and gradient helpers for the Sobel edge pipeline.
package sobel_pkg;
    localparam int PIX_W = 8;
    localparam int GRAD_W = 11;
    localparam int MAG_W = 12;
    localparam logic [MAG_W-1:0] MAG_MAX = MAG_W'(255);

    // win[row][col]: row 0 is the oldest line, col 2 the newest pixel
    typedef logic [2:0][2:0][PIX_W-1:0] win_t;

    function automatic logic signed [GRAD_W-1:0] ext(input logic [PIX_W-1:0] p);
        return $signed({{(GRAD_W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic [GRAD_W-1:0] abs_grad(input logic signed [GRAD_W-1:0] g);
        return g[GRAD_W-1] ? -g : g;
    endfunction
endpackage

// File: rtl/sobel_line_buf.sv
// sobel_line_buf: two column-addressed line delays giving the line-1 and line-2 taps.
module sobel_line_buf #(
    parameter int DEPTH = 640,
    parameter int W = 8,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  tap1,
    output logic [W-1:0]  tap2
);
    logic [W-1:0] mem1 [DEPTH];
    logic [W-1:0] mem2 [DEPTH];

    assign tap1 = mem1[addr];
    assign tap2 = mem2[addr];

    always_ff @(posedge clk)
        if (en) begin
            mem1[addr] <= din;
            mem2[addr] <= mem1[addr];
        end
endmodule

// File: rtl/sobel_edge.sv
// sobel_edge: 3-stage Sobel edge magnitude pipeline with border masking.
// Define SOBEL_BINARY_OUT_EN to binarise the saturated magnitude against thr.
module sobel_edge
    import sobel_pkg::*;
#(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PIX_W-1:0] din,
    input  logic             din_vld,
    input  logic             din_sop,
    input  logic             din_eop,
    input  logic [PIX_W-1:0] thr,
    output logic [PIX_W-1:0] dout,
    output logic             dout_vld,
    output logic             dout_sop,
    output logic             dout_eop
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0] col, c;
    logic [RW-1:0] row, r;
    logic in_frame;
    logic [PIX_W-1:0] tap1, tap2, thr1, thr2, sat, res;
    win_t win;
    logic vld1, sop1, eop1, bord1, vld2, sop2, eop2, bord2;
    logic signed [GRAD_W-1:0] gx, gy;
    logic [GRAD_W-1:0] ax2, ay2;
    logic [MAG_W-1:0] mag;

    assign c = din_sop ? '0 : col;
    assign r = din_sop ? '0 : row;

    sobel_line_buf #(.DEPTH(IMG_W), .W(PIX_W), .AW(CW)) u_line_buf (
        .clk  (clk),
        .en   (din_vld),
        .addr (c),
        .din  (din),
        .tap1 (tap1),
        .tap2 (tap2)
    );

    // Beats seen after reset but before any sop are masked like the border.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            col <= '0;
            row <= '0;
            in_frame <= 1'b0;
            win <= '0;
            vld1 <= 1'b0;
            sop1 <= 1'b0;
            eop1 <= 1'b0;
            bord1 <= 1'b0;
            thr1 <= '0;
        end else begin
            vld1 <= din_vld;
            sop1 <= din_vld & din_sop;
            eop1 <= din_vld & din_eop;
            if (din_vld) begin
                col <= (c == COL_LAST) ? '0 : c + 1'b1;
                row <= (c == COL_LAST && r != ROW_LAST) ? r + 1'b1 : r;
                in_frame <= in_frame | din_sop;
                win <= {din, win[2][2:1], tap1, win[1][2:1], tap2, win[0][2:1]};
                bord1 <= (r[RW-1:1] == '0) | (c[CW-1:1] == '0) | ~(in_frame | din_sop);
                thr1 <= thr;
            end
        end

    assign gx = ext(win[0][2]) + (ext(win[1][2]) <<< 1) + ext(win[2][2])
              - ext(win[0][0]) - (ext(win[1][0]) <<< 1) - ext(win[2][0]);
    assign gy = ext(win[2][0]) + (ext(win[2][1]) <<< 1) + ext(win[2][2])
              - ext(win[0][0]) - (ext(win[0][1]) <<< 1) - ext(win[0][2]);

    assign mag = {1'b0, ax2} + {1'b0, ay2};
    assign sat = (mag > MAG_MAX) ? PIX_W'(MAG_MAX) : mag[PIX_W-1:0];
`ifdef SOBEL_BINARY_OUT_EN
    assign res = (sat >= thr2) ? PIX_W'(MAG_MAX) : '0;
`else
    logic unused_thr;
    assign unused_thr = ^thr2;
    assign res = sat;
`endif

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            ax2 <= '0;
            ay2 <= '0;
            thr2 <= '0;
            vld2 <= 1'b0;
            sop2 <= 1'b0;
            eop2 <= 1'b0;
            bord2 <= 1'b0;
            dout <= '0;
            dout_vld <= 1'b0;
            dout_sop <= 1'b0;
            dout_eop <= 1'b0;
        end else begin
            vld2 <= vld1;
            sop2 <= sop1;
            eop2 <= eop1;
            if (vld1) begin
                ax2 <= abs_grad(gx);
                ay2 <= abs_grad(gy);
                bord2 <= bord1;
                thr2 <= thr1;
            end
            dout_vld <= vld2;
            dout_sop <= sop2;
            dout_eop <= eop2;
            if (vld2)
                dout <= bord2 ? '0 : res;
        end
endmodule

// File: tb/tb_sobel_edge.sv
// tb_sobel_edge: random-gap frames against an image-level Sobel reference model.
module tb_sobel_edge;
    localparam int W = 8;
    localparam int H = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] din = '0, thr = '0, dout;
    logic din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
    logic dout_vld, dout_sop, dout_eop;

    typedef struct {
        int pix;
        bit sop;
        bit eop;
        int cyc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int img [8][W];
    int cyc = 0, n_vec = 0, n_err = 0, n_out = 0, last_exp = 0, fix_thr = -1;
    bit mon_en = 1'b0;

    sobel_edge #(.IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .din      (din),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din_eop  (din_eop),
        .thr      (thr),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Saturated |Gx|+|Gy| over the 3x3 neighbourhood ending at image pixel (r,c).
    function automatic int model(input int r, input int c);
        int gx, gy, m;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
        m = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return m > 255 ? 255 : m;
    endfunction

    task automatic fill(input int kind);
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = kind == 0 ? 100 :
                            kind == 1 ? (c < 4 ? 0 : 200) :
                            kind == 2 ? 10 * c : int'($urandom_range(255));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            din_vld = 1'b0;
            din_sop = 1'b0;
            din_eop = 1'b0;
            din = 8'($urandom);
        end
    endtask

    task automatic beat(input int r, input int c, input bit s, input bit en);
        exp_t x;
        int t;
        t = fix_thr >= 0 ? fix_thr : int'($urandom_range(255));
        @(posedge clk); #1;
        din = 8'(img[r][c]);
        din_vld = 1'b1;
        din_sop = s;
        din_eop = en;
        thr = 8'(t);
        x.pix = model(r, c);
`ifdef SOBEL_BINARY_OUT_EN
        x.pix = x.pix >= t ? 255 : 0;
`endif
        x.sop = s;
        x.eop = en;
        x.cyc = cyc;
        q.push_back(x);
    endtask

    task automatic send_frame(input int rows, input int gap_pct, input int stop);
        int n = 0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < W; c++) begin
                if (stop >= 0 && n == stop) return;
                while (int'($urandom_range(99)) < gap_pct) idle(1);
                beat(r, c, r == 0 && c == 0, r == rows - 1 && c == W - 1);
                n++;
            end
    endtask

    task automatic drain();
        idle(1);
        for (int i = 0; i < 40 && q.size() > 0; i++) idle(1);
        check("drain", q.size(), 0);
    endtask

    task automatic check_reset_outputs();
        check("rst_dout", dout, 0);
        check("rst_vld", dout_vld, 0);
        check("rst_sop", dout_sop, 0);
        check("rst_eop", dout_eop, 0);
    endtask

    always @(negedge clk)
        if (mon_en && rst_n) begin
            if (dout_vld) begin
                if (q.size() == 0) check("extra_vld", dout_vld, 0);
                else begin
                    e = q.pop_front();
                    check("dout", dout, e.pix);
                    check("sop", dout_sop, e.sop);
                    check("eop", dout_eop, e.eop);
                    check("latency", cyc - e.cyc, 3);
                    last_exp = e.pix;
                    n_out++;
                end
            end else begin
                check("hold", dout, last_exp);
            end
        end

    initial begin
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 check_reset_outputs();
        rst_n = 1'b1;
        mon_en = 1'b1;

        fill(0);
        n_out = 0;
        send_frame(H, 0, -1);
        drain();
        check("flat_pulses", n_out, W * H);

        fill(1);
        send_frame(H, 0, -1);
        drain();

        fill(2);
`ifdef SOBEL_BINARY_OUT_EN
        fix_thr = 80;
        send_frame(H, 0, -1);
        drain();
        fix_thr = 81;
        send_frame(H, 0, -1);
        drain();
        fix_thr = -1;
`else
        send_frame(H, 0, -1);
        drain();
`endif

        fill(3);
        send_frame(H, 0, -1);
        send_frame(H, 50, -1);
        drain();

        fill(3);
        send_frame(H, 0, -1);
        fill(2);
        send_frame(H, 0, -1);
        fill(3);
        send_frame(H, 0, -1);
        drain();

        fill(3);
        send_frame(6, 20, -1);
        drain();

        fill(3);
        send_frame(H, 0, 2 * W + 3);
        @(posedge clk); #1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        rst_n = 1'b0;
        q.delete();
        last_exp = 0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        fill(3);
        send_frame(H, 30, -1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sobel_edge.md
SOBEL_EDGE -- requirements
Module: sobel_edge

Interface
REQ-001 Parameter IMG_W, default 640, pixels per line (line-buffer depth and column wrap point).
REQ-002 Parameter IMG_H, default 480, lines per frame (row-counter saturation point).
REQ-003 clk  input  1  clock; all flops sample on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 din  input  8  Gaussian-filtered grey pixel.
REQ-006 din_vld  input  1  din valid this cycle; no backpressure.
REQ-007 din_sop  input  1  first pixel of frame, qualified by din_vld.
REQ-008 din_eop  input  1  last pixel of frame, qualified by din_vld.
REQ-009 thr  input  8  binarisation threshold, sampled every valid beat.
REQ-010 dout  output  8  edge magnitude, or binary edge value (REQ-025).
REQ-011 dout_vld, dout_sop, dout_eop  output  1 each  din_vld/sop/eop delayed by exactly 3 clk.

Function
REQ-012 On each din_vld beat, the 3x3 window shall shift one column: the new column is {line-2, line-1, din} at the current column.
REQ-013 Line buffers, window registers and counters shall advance only on din_vld beats; idle cycles shall hold all state.
REQ-014 Column counter 0..IMG_W-1 shall wrap to 0 after IMG_W-1 and increment row counter; row counter shall saturate at IMG_H-1.
REQ-015 din_sop with din_vld shall force column=0, row=0 for that beat, overriding any wrap in the same cycle.
REQ-016 din_eop shall not clear counters; the next din_sop does.
REQ-017 Gx = (p02+2*p12+p22)-(p00+2*p10+p20); Gy = (p20+2*p21+p22)-(p00+2*p01+p02); p[row][col], row 0 oldest line, col 2 newest pixel; signed 11-bit.
REQ-018 mag = |Gx|+|Gy| in 12 bits unsigned; saturate to 255 when mag > 255.
REQ-019 Pipeline: stage 1 window update; stage 2 Gx/Gy absolute values; stage 3 sum, saturation, output register.
REQ-020 Latency shall be exactly 3 clk from the din_vld beat to the matching dout_vld pulse, for any gaps in the input stream.
REQ-021 Border: when the beat's row < 2 or column < 2, dout shall be 0 while dout_vld still asserts.
REQ-022 dout shall hold its last value when dout_vld is low.
REQ-023 Back-to-back frames (din_eop beat followed immediately by din_sop beat) shall be processed without a lost beat.

Reset
REQ-024 rst_n low shall asynchronously clear dout, dout_vld/sop/eop, counters, window registers and pipeline registers to 0; line-buffer contents need not be cleared; reset mid-frame shall discard the frame and processing shall restart at the next din_sop.

Configuration
REQ-025 Macro SOBEL_BINARY_OUT_EN defined: dout = 255 when saturated mag >= thr, else 0 (border beats still 0); undefined: dout = saturated magnitude and thr is ignored; latency identical in both builds.

Structure
REQ-026 Package sobel_pkg shall hold PIX_W=8, GRAD_W=11, MAG_W=12, MAG_MAX=255.
REQ-027 Sub-module sobel_line_buf shall implement the two IMG_W-deep line delays with a clock enable and provide the line-1 and line-2 taps.

Verification
REQ-028 Flat frame, all pixels 100, IMG_W=8, IMG_H=4 -> every dout=0; 32 dout_vld pulses; dout_sop on the first and dout_eop on the last, each 3 clk after its input.
REQ-029 Vertical step (columns 0-3 = 0, columns 4-7 = 200), magnitude build -> interior beats at columns 4 and 5 = 255 (saturated), others 0.
REQ-030 Ramp column value = 10*col, magnitude build -> interior dout = 80 (|Gx|=80, Gy=0).
REQ-031 SOBEL_BINARY_OUT_EN, ramp as REQ-030, thr=80 then thr=81 -> interior 255, then 0.
REQ-032 Random din_vld gaps (~50% duty) -> dout sequence identical to the gap-free run; every dout_vld exactly 3 clk after its beat.
REQ-033 rst_n pulsed mid-row 2, then new frame -> outputs 0 during reset; new frame matches a clean run, rows 0-1 zero.
